// File: rtl/pcs_receive.sv
// pcs_receive: 1000BASE-X PCS receive path. Decodes 8B/10B code-groups and rebuilds GMII RXD/RX_DV/RX_ER.
// Latency: 1 clock. The code-group sampled at edge k drives the outputs from edge k until edge k+1.
// Backpressure: none. One code-group is consumed every clock.
// Ports: Clk, mr_main_reset (synchronous, active-high), code_sync_status (sync acquired),
//        SUDI {rx_even, code-group a..j with a at bit 9}, RXD/RX_DV/RX_ER (GMII receive),
//        receiving (a packet is in progress).
module pcs_receive (
  input  logic        Clk,
  input  logic        mr_main_reset,
  input  logic        code_sync_status,
  input  logic [10:0] SUDI,
  output logic [7:0]  RXD,
  output logic        RX_DV,
  output logic        RX_ER,
  output logic        receiving
);

  typedef enum logic [2:0] {CG_DATA, CG_K285, CG_S, CG_T, CG_R, CG_V, CG_INV} cg_class_t;
  typedef enum logic [2:0] {LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D, RECEIVE, TRI_RRI} rx_state_t;

  // Special code-groups in their RD- form. The RD+ form is the bitwise complement.
  localparam logic [9:0] K285_CG = 10'b0011111010;
  localparam logic [9:0] S_CG    = 10'b1101101000;
  localparam logic [9:0] T_CG    = 10'b1011101000;
  localparam logic [9:0] R_CG    = 10'b1110101000;
  localparam logic [9:0] V_CG    = 10'b0111101000;

  logic [9:0] cg;
  logic       rx_even;
  logic [4:0] dec5;
  logic       vld6;
  logic [2:0] dec3;
  logic       vld4;
  cg_class_t  cls;
  logic       k_even;

  assign cg      = SUDI[9:0];
  assign rx_even = SUDI[10];

  // 5b/6b decode on abcdei. Both disparity columns are listed, and disparity is ignored.
  always_comb begin
    vld6 = 1'b1;
    dec5 = 5'd0;
    case (cg[9:4])
      6'b100111, 6'b011000: dec5 = 5'd0;
      6'b011101, 6'b100010: dec5 = 5'd1;
      6'b101101, 6'b010010: dec5 = 5'd2;
      6'b110001:            dec5 = 5'd3;
      6'b110101, 6'b001010: dec5 = 5'd4;
      6'b101001:            dec5 = 5'd5;
      6'b011001:            dec5 = 5'd6;
      6'b111000, 6'b000111: dec5 = 5'd7;
      6'b111001, 6'b000110: dec5 = 5'd8;
      6'b100101:            dec5 = 5'd9;
      6'b010101:            dec5 = 5'd10;
      6'b110100:            dec5 = 5'd11;
      6'b001101:            dec5 = 5'd12;
      6'b101100:            dec5 = 5'd13;
      6'b011100:            dec5 = 5'd14;
      6'b010111, 6'b101000: dec5 = 5'd15;
      6'b011011, 6'b100100: dec5 = 5'd16;
      6'b100011:            dec5 = 5'd17;
      6'b010011:            dec5 = 5'd18;
      6'b110010:            dec5 = 5'd19;
      6'b001011:            dec5 = 5'd20;
      6'b101010:            dec5 = 5'd21;
      6'b011010:            dec5 = 5'd22;
      6'b111010, 6'b000101: dec5 = 5'd23;
      6'b110011, 6'b001100: dec5 = 5'd24;
      6'b100110:            dec5 = 5'd25;
      6'b010110:            dec5 = 5'd26;
      6'b110110, 6'b001001: dec5 = 5'd27;
      6'b001110:            dec5 = 5'd28;
      6'b101110, 6'b010001: dec5 = 5'd29;
      6'b011110, 6'b100001: dec5 = 5'd30;
      6'b101011, 6'b010100: dec5 = 5'd31;
      default:              vld6 = 1'b0;
    endcase
  end

  // 3b/4b decode on fghj. The primary and alternate .7 encodings both map to 7.
  always_comb begin
    vld4 = 1'b1;
    dec3 = 3'd0;
    case (cg[3:0])
      4'b1011, 4'b0100:                   dec3 = 3'd0;
      4'b1001:                            dec3 = 3'd1;
      4'b0101:                            dec3 = 3'd2;
      4'b1100, 4'b0011:                   dec3 = 3'd3;
      4'b1101, 4'b0010:                   dec3 = 3'd4;
      4'b1010:                            dec3 = 3'd5;
      4'b0110:                            dec3 = 3'd6;
      4'b1110, 4'b0001, 4'b0111, 4'b1000: dec3 = 3'd7;
      default:                            vld4 = 1'b0;
    endcase
  end

  // The specials are matched first. /S/, /T/, /R/ and /V/ would otherwise alias to Dx.7 data.
  always_comb begin
    cls = CG_INV;
    if (cg == K285_CG || cg == ~K285_CG)   cls = CG_K285;
    else if (cg == S_CG || cg == ~S_CG)    cls = CG_S;
    else if (cg == T_CG || cg == ~T_CG)    cls = CG_T;
    else if (cg == R_CG || cg == ~R_CG)    cls = CG_R;
    else if (cg == V_CG || cg == ~V_CG)    cls = CG_V;
    else if (vld6 && vld4)                 cls = CG_DATA;
  end

  assign k_even = (cls == CG_K285) && rx_even;

  rx_state_t  state_q, state_d;
  logic [7:0] rxd_q, rxd_d;
  logic       rx_dv_q, rx_dv_d;
  logic       rx_er_q, rx_er_d;
  logic       receiving_q, receiving_d;

  always_comb begin
    state_d = state_q;
    rxd_d   = 8'h00;
    rx_dv_d = 1'b0;
    rx_er_d = 1'b0;
    if (!code_sync_status) begin
      state_d = LINK_FAILED;
      // Losing sync mid-packet terminates the frame with one error cycle.
      if (state_q == RECEIVE) begin
        rx_dv_d = 1'b1;
        rx_er_d = 1'b1;
      end
    end else begin
      case (state_q)
        LINK_FAILED: state_d = WAIT_FOR_K;
        WAIT_FOR_K:  if (k_even) state_d = RX_K;
        RX_K:        state_d = (cls == CG_DATA) ? IDLE_D : WAIT_FOR_K;
        IDLE_D: begin
          if (k_even) begin
            state_d = RX_K;
          end else if (cls == CG_S) begin
            state_d = RECEIVE;
            rxd_d   = 8'h55;
            rx_dv_d = 1'b1;
          end else begin
            state_d = WAIT_FOR_K;
          end
        end
        RECEIVE: begin
          if (cls == CG_DATA) begin
            rxd_d   = {dec3, dec5};
            rx_dv_d = 1'b1;
          end else if (cls == CG_T) begin
            state_d = TRI_RRI;
          end else if (k_even) begin
            state_d = RX_K;
            rx_dv_d = 1'b1;
            rx_er_d = 1'b1;
          end else begin
            rx_dv_d = 1'b1;
            rx_er_d = 1'b1;
          end
        end
        TRI_RRI: begin
          if (k_even)              state_d = RX_K;
          else if (cls != CG_R)    state_d = WAIT_FOR_K;
        end
        default: state_d = LINK_FAILED;
      endcase
    end
    receiving_d = (state_d == RECEIVE);
  end

  always_ff @(posedge Clk) begin
    if (mr_main_reset) begin
      state_q     <= LINK_FAILED;
      rxd_q       <= 8'h00;
      rx_dv_q     <= 1'b0;
      rx_er_q     <= 1'b0;
      receiving_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rxd_q       <= rxd_d;
      rx_dv_q     <= rx_dv_d;
      rx_er_q     <= rx_er_d;
      receiving_q <= receiving_d;
    end
  end

  assign RXD       = rxd_q;
  assign RX_DV     = rx_dv_q;
  assign RX_ER     = rx_er_q;
  assign receiving = receiving_q;

endmodule

// File: tb/tb_pcs_receive.sv
// tb_pcs_receive: random packet traffic against an encoder-side expectation of pcs_receive.
// Each code-group is driven for one clock. The registered outputs are compared 1 time unit after that edge.
// Expected output word layout: {RXD, RX_DV, RX_ER, receiving}.
module tb_pcs_receive;

  logic        Clk = 1'b0;
  logic        mr_main_reset;
  logic        code_sync_status;
  logic [10:0] SUDI;
  logic [7:0]  RXD;
  logic        RX_DV;
  logic        RX_ER;
  logic        receiving;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [9:0]  K285 = 10'b0011111010;
  localparam logic [9:0]  S_CG = 10'b1101101000;
  localparam logic [9:0]  T_CG = 10'b1011101000;
  localparam logic [9:0]  R_CG = 10'b1110101000;
  localparam logic [9:0]  V_CG = 10'b0111101000;
  localparam logic [9:0]  D1_0 = 10'b0111010100;

  localparam logic [10:0] EXP_IDLE    = 11'd0;
  localparam logic [10:0] EXP_SOP     = {8'h55, 3'b101};
  localparam logic [10:0] EXP_ERR     = {8'h00, 3'b111};
  localparam logic [10:0] EXP_END_ERR = {8'h00, 3'b110};

  pcs_receive dut (
    .Clk              (Clk),
    .mr_main_reset    (mr_main_reset),
    .code_sync_status (code_sync_status),
    .SUDI             (SUDI),
    .RXD              (RXD),
    .RX_DV            (RX_DV),
    .RX_ER            (RX_ER),
    .receiving        (receiving)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rxd=%h dv=%b er=%b rcv=%b, expected rxd=%h dv=%b er=%b rcv=%b",
               tag, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Specials are sent in either running-disparity form at random.
  function automatic logic [9:0] rd_flip(input logic [9:0] c);
    return rbit() ? ~c : c;
  endfunction

  // RD- column of the 5b/6b code, abcdei order.
  function automatic logic [5:0] six_rdm(input logic [4:0] x);
    case (x)
      5'd0:  return 6'b100111;  5'd1:  return 6'b011101;  5'd2:  return 6'b101101;
      5'd3:  return 6'b110001;  5'd4:  return 6'b110101;  5'd5:  return 6'b101001;
      5'd6:  return 6'b011001;  5'd7:  return 6'b111000;  5'd8:  return 6'b111001;
      5'd9:  return 6'b100101;  5'd10: return 6'b010101;  5'd11: return 6'b110100;
      5'd12: return 6'b001101;  5'd13: return 6'b101100;  5'd14: return 6'b011100;
      5'd15: return 6'b010111;  5'd16: return 6'b011011;  5'd17: return 6'b100011;
      5'd18: return 6'b010011;  5'd19: return 6'b110010;  5'd20: return 6'b001011;
      5'd21: return 6'b101010;  5'd22: return 6'b011010;  5'd23: return 6'b111010;
      5'd24: return 6'b110011;  5'd25: return 6'b100110;  5'd26: return 6'b010110;
      5'd27: return 6'b110110;  5'd28: return 6'b001110;  5'd29: return 6'b101110;
      5'd30: return 6'b011110;  default: return 6'b101011;
    endcase
  endfunction

  // RD- column of the 3b/4b code, fghj order. Primary .7 only, so /S/ /T/ /R/ /V/ are never produced.
  function automatic logic [3:0] four_rdm(input logic [2:0] y);
    case (y)
      3'd0: return 4'b1011;  3'd1: return 4'b1001;  3'd2: return 4'b0101;
      3'd3: return 4'b1100;  3'd4: return 4'b1101;  3'd5: return 4'b1010;
      3'd6: return 4'b0110;  default: return 4'b1110;
    endcase
  endfunction

  // Encoder. Each sub-block independently takes the RD+ column at random.
  // RD+ is the complement for unbalanced codes and for the balanced D.7 and .3 special cases.
  function automatic logic [9:0] enc(input logic [7:0] oct);
    logic [5:0] s6;
    logic [3:0] s4;
    s6 = six_rdm(oct[4:0]);
    s4 = four_rdm(oct[7:5]);
    if (($countones(s6) != 3 || oct[4:0] == 5'd7) && rbit()) s6 = ~s6;
    if (($countones(s4) != 2 || oct[7:5] == 3'd3) && rbit()) s4 = ~s4;
    return {s6, s4};
  endfunction

  // Patterns that are in neither column. The all-0 and all-1 sub-blocks are never legal.
  function automatic logic [9:0] bad_cg();
    logic [9:0] r;
    r = 10'($urandom);
    case ($urandom_range(0, 3))
      0:       r = 10'h3FF;
      1:       r[3:0] = 4'b1111;
      2:       r[3:0] = 4'b0000;
      default: r[9:4] = 6'b111111;
    endcase
    return r;
  endfunction

  function automatic logic [10:0] exp_data(input logic [7:0] oct);
    return {oct, 3'b101};
  endfunction

  task automatic step(input logic [9:0] cg, input logic even, input logic sync, input logic rst,
                      input logic [10:0] exp, input string tag);
    SUDI             = {even, cg};
    code_sync_status = sync;
    mr_main_reset    = rst;
    @(posedge Clk);
    #1;
    check_eq(tag, {RXD, RX_DV, RX_ER, receiving}, exp);
  endtask

  // K28.5 on an even slot followed by data. This leaves the receiver idle and ready for /S/.
  task automatic idle_pair();
    step(rd_flip(K285), 1'b1, 1'b1, 1'b0, EXP_IDLE, "idle_k");
    step(enc(8'($urandom)), 1'b0, 1'b1, 1'b0, EXP_IDLE, "idle_d");
  endtask

  // Recover from link failure. The first synced code-group is only an acknowledgement.
  // Filler follows that cannot be K28.5 on an even slot, and then idle.
  task automatic relock();
    step(10'($urandom), rbit(), 1'b1, 1'b0, EXP_IDLE, "relock");
    repeat ($urandom_range(0, 3)) begin
      if (rbit()) step(rd_flip(K285), 1'b0, 1'b1, 1'b0, EXP_IDLE, "wait_k_odd");
      else        step(enc(8'($urandom)), rbit(), 1'b1, 1'b0, EXP_IDLE, "wait_k_data");
    end
    idle_pair();
    idle_pair();
  endtask

  task automatic send_err(input string tag);
    case ($urandom_range(0, 4))
      0:       step(bad_cg(), rbit(), 1'b1, 1'b0, EXP_ERR, tag);
      1:       step(rd_flip(V_CG), rbit(), 1'b1, 1'b0, EXP_ERR, tag);
      2:       step(rd_flip(S_CG), rbit(), 1'b1, 1'b0, EXP_ERR, tag);
      3:       step(rd_flip(R_CG), rbit(), 1'b1, 1'b0, EXP_ERR, tag);
      default: step(rd_flip(K285), 1'b0, 1'b1, 1'b0, EXP_ERR, tag);
    endcase
  endtask

  // The packet starts from idle and always leaves the receiver idle again.
  // end_kind: 0 = /T/ plus /R/s, 1 = early end, 2 = sync loss, 3 = reset.
  task automatic packet(input int n, input int err_pct, input int end_kind);
    step(rd_flip(S_CG), rbit(), 1'b1, 1'b0, EXP_SOP, "sop");
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < err_pct) begin
        send_err("pkt_err");
      end else begin
        logic [7:0] o;
        o = 8'($urandom);
        step(enc(o), rbit(), 1'b1, 1'b0, exp_data(o), "pkt_data");
      end
    end
    case (end_kind)
      0: begin
        step(rd_flip(T_CG), rbit(), 1'b1, 1'b0, EXP_IDLE, "tail_t");
        repeat ($urandom_range(0, 3)) step(rd_flip(R_CG), rbit(), 1'b1, 1'b0, EXP_IDLE, "tail_r");
        if ($urandom_range(0, 3) == 0) step(enc(8'($urandom)), rbit(), 1'b1, 1'b0, EXP_IDLE, "tail_other");
        idle_pair();
      end
      1: begin
        step(rd_flip(K285), 1'b1, 1'b1, 1'b0, EXP_END_ERR, "early_end");
        step(enc(8'($urandom)), 1'b0, 1'b1, 1'b0, EXP_IDLE, "early_end_d");
      end
      2: begin
        step(rbit() ? rd_flip(T_CG) : enc(8'($urandom)), rbit(), 1'b0, 1'b0, EXP_END_ERR, "sync_loss");
        step(10'($urandom), rbit(), 1'b0, 1'b0, EXP_IDLE, "link_failed");
        relock();
      end
      default: begin
        step(enc(8'($urandom)), rbit(), rbit(), 1'b1, EXP_IDLE, "rst_mid");
        relock();
      end
    endcase
  endtask

  // Fixed short packet: 55, 01, 03, 9A (or an invalid code-group), B5, then /T/ /R/ K28.5.
  task automatic short_packet(input logic inv);
    step(rd_flip(S_CG), 1'b0, 1'b1, 1'b0, EXP_SOP, "sp_sop");
    step(D1_0, 1'b1, 1'b1, 1'b0, exp_data(8'h01), "sp_d1_0");
    step(enc(8'h03), 1'b0, 1'b1, 1'b0, exp_data(8'h03), "sp_d3_0");
    if (inv) step(10'h3FF, 1'b1, 1'b1, 1'b0, EXP_ERR, "sp_invalid");
    else     step(enc(8'h9A), 1'b1, 1'b1, 1'b0, exp_data(8'h9A), "sp_d26_4");
    step(enc(8'hB5), 1'b0, 1'b1, 1'b0, exp_data(8'hB5), "sp_d21_5");
    step(rd_flip(T_CG), 1'b1, 1'b1, 1'b0, EXP_IDLE, "sp_t");
    step(rd_flip(R_CG), 1'b0, 1'b1, 1'b0, EXP_IDLE, "sp_r");
    step(rd_flip(K285), 1'b1, 1'b1, 1'b0, EXP_IDLE, "sp_k");
    step(enc(8'h50), 1'b0, 1'b1, 1'b0, EXP_IDLE, "sp_idle_d");
  endtask

  initial begin
    mr_main_reset    = 1'b1;
    code_sync_status = 1'b0;
    SUDI             = 11'd0;

    // Reset with arbitrary inputs.
    step(10'($urandom), rbit(), rbit(), 1'b1, EXP_IDLE, "reset_0");
    step(10'($urandom), rbit(), rbit(), 1'b1, EXP_IDLE, "reset_1");
    step(10'($urandom), rbit(), 1'b0, 1'b0, EXP_IDLE, "lf_no_sync");

    // Idle lock: alternate K28.5 (even) and D16.2 (odd).
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) step(rd_flip(K285), 1'b1, 1'b1, 1'b0, EXP_IDLE, "lock_k");
      else            step(enc(8'h50), 1'b0, 1'b1, 1'b0, EXP_IDLE, "lock_d16_2");
    end

    short_packet(1'b0);
    short_packet(1'b1);

    // Early end.
    step(rd_flip(S_CG), 1'b0, 1'b1, 1'b0, EXP_SOP, "ee_sop");
    step(D1_0, 1'b1, 1'b1, 1'b0, exp_data(8'h01), "ee_d1_0");
    step(rd_flip(K285), 1'b1, 1'b1, 1'b0, EXP_END_ERR, "ee_k");
    step(enc(8'h50), 1'b0, 1'b1, 1'b0, EXP_IDLE, "ee_rx_k_d");

    // Sync loss at the same edge as /T/. The error cycle wins.
    step(rd_flip(S_CG), 1'b0, 1'b1, 1'b0, EXP_SOP, "sl_sop");
    step(D1_0, 1'b1, 1'b1, 1'b0, exp_data(8'h01), "sl_d1_0");
    step(rd_flip(T_CG), 1'b0, 1'b0, 1'b0, EXP_END_ERR, "sl_t_nosync");
    step(rd_flip(K285), 1'b1, 1'b0, 1'b0, EXP_IDLE, "sl_link_failed");
    relock();

    // Reset mid-packet: outputs clear on the same edge with no error cycle.
    step(rd_flip(S_CG), 1'b0, 1'b1, 1'b0, EXP_SOP, "rm_sop");
    step(D1_0, 1'b1, 1'b1, 1'b0, exp_data(8'h01), "rm_d1_0");
    step(enc(8'h9A), 1'b0, 1'b1, 1'b1, EXP_IDLE, "rm_reset");
    step(rd_flip(K285), 1'b1, 1'b1, 1'b0, EXP_IDLE, "rm_after");
    step(enc(8'h50), 1'b0, 1'b1, 1'b0, EXP_IDLE, "rm_wait_k");
    idle_pair();

    // Random traffic.
    repeat (250) begin
      int r;
      repeat ($urandom_range(1, 3)) idle_pair();
      r = $urandom_range(0, 9);
      packet($urandom_range(0, 12), rbit() ? 15 : 0,
             (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? 2 : 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
